// File: rtl/spi_byte_master.sv
// SPI byte master, mode 3 (CPOL=1, CPHA=1), MSB first, one byte per request.
// Define SPI_LOOPBACK_EN to feed the receive sampler from the internal mosi bit instead of miso.
module spi_byte_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_start,
  input  logic       spi_tx_valid,
  input  logic [7:0] spi_tx_data,
  output logic       spi_tx_ready,
  output logic       spi_rx_valid,
  output logic [7:0] spi_rx_data,
  output logic       spi_busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state, state_next;
  logic [DIV_W-1:0] div_q;
  logic [4:0]       edge_cnt;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic             sclk_q;
  logic             sample;
  logic             accept;
  logic             tick;

  assign accept = (state == IDLE) && spi_start && spi_tx_valid;
  assign tick   = (state == SHIFT) && (div_q == DIV_LAST);

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign sample      = tx_sr[7];
`else
  assign sample = miso;
`endif

  // NOTE: every clocked process uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (tick && edge_cnt == 5'd15) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    spi_busy     = (state != IDLE);
    spi_tx_ready = (state == IDLE);
    sclk         = (state == SHIFT) ? sclk_q   : 1'b1;
    mosi         = (state == SHIFT) ? tx_sr[7] : 1'b0;
  end

  // Edge index k = edge_cnt + 1: odd k falls, even k rises; mosi holds bit 7 through edges 1-2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sclk_q   <= 1'b1;
    end else if (accept) begin
      div_q    <= '0;
      edge_cnt <= '0;
      tx_sr    <= spi_tx_data;
      rx_sr    <= '0;
      sclk_q   <= 1'b1;
    end else if (state == SHIFT) begin
      if (tick) begin
        div_q    <= '0;
        edge_cnt <= edge_cnt + 5'd1;
        if (!edge_cnt[0]) begin
          sclk_q <= 1'b0;
          if (edge_cnt != 5'd0) tx_sr <= {tx_sr[6:0], 1'b0};
        end else begin
          sclk_q <= 1'b1;
          rx_sr  <= {rx_sr[6:0], sample};
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  // Received byte is published only from DONE, so an aborted transfer never leaks partial data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_rx_valid <= 1'b0;
      spi_rx_data  <= 8'h00;
    end else begin
      spi_rx_valid <= (state == DONE);
      if (state == DONE) spi_rx_data <= rx_sr;
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench for spi_byte_master with a mode-3 slave model and a byte-level reference model.
// Expectations follow SPI_LOOPBACK_EN when the bench is built with that macro.
module tb_spi_byte_master;

  localparam int unsigned CLK_DIV = 2;
  localparam int          LAT     = 16 * CLK_DIV + 1;

  logic       clk;
  logic       rst_n;
  logic       spi_start;
  logic       spi_tx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_ready;
  logic       spi_rx_valid;
  logic [7:0] spi_rx_data;
  logic       spi_busy;
  logic       sclk;
  logic       mosi;
  logic       miso;

  int vectors;
  int miscompares;

  logic [7:0] slave_byte;
  logic [7:0] slave_sr;
  bit         mosi_q[$];
  int         valid_cnt;
  int         fall_cnt;
  logic       prev_sclk;
  logic       prev_mosi;

  spi_byte_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_start    (spi_start),
    .spi_tx_valid (spi_tx_valid),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_ready (spi_tx_ready),
    .spi_rx_valid (spi_rx_valid),
    .spi_rx_data  (spi_rx_data),
    .spi_busy     (spi_busy),
    .sclk         (sclk),
    .mosi         (mosi),
    .miso         (miso)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mode-3 slave: reloads on busy rising, presents the next bit after each falling sclk edge.
  always @(negedge sclk or posedge spi_busy) begin
    if (!sclk) begin
      miso     = slave_sr[7];
      slave_sr = {slave_sr[6:0], 1'b0};
    end else begin
      slave_sr = slave_byte;
    end
  end

  // Observer: mosi seen just before each sclk rise, falling-edge count, rx_valid cycle count.
  always @(posedge clk) begin
    #2;
    if (sclk === 1'b1 && prev_sclk === 1'b0) mosi_q.push_back(prev_mosi);
    if (sclk === 1'b0 && prev_sclk === 1'b1) fall_cnt++;
    if (spi_rx_valid === 1'b1) valid_cnt++;
    prev_sclk = sclk;
    prev_mosi = mosi;
  end

  // Reference model: the slave returns its byte, or the transmitted byte when looped back.
  function automatic logic [7:0] expected_rx(input logic [7:0] tx, input logic [7:0] sl);
`ifdef SPI_LOOPBACK_EN
    return tx;
`else
    return sl;
`endif
  endfunction

  function automatic logic [7:0] observed_mosi(input int base);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++)
      if (base + i < mosi_q.size()) b[7-i] = mosi_q[base+i];
    return b;
  endfunction

  // Caller sits at a negedge; returns at the negedge after the accepting edge.
  task automatic start_byte(input logic [7:0] tx, input logic [7:0] sl, output int base);
    slave_byte   = sl;
    spi_tx_data  = tx;
    spi_start    = 1'b1;
    spi_tx_valid = 1'b1;
    base         = mosi_q.size();
    @(posedge clk);
    @(negedge clk);
    spi_start    = 1'b0;
    spi_tx_valid = 1'b0;
    spi_tx_data  = 8'($urandom);
  endtask

  // Counts clk edges after acceptance until rx_valid; optionally injects a stray start mid-transfer.
  task automatic wait_done(input bit inject, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (inject && cyc >= 8 && cyc <= 10) begin
        spi_start    = 1'b1;
        spi_tx_valid = 1'b1;
        spi_tx_data  = 8'hFF;
      end else begin
        spi_start    = 1'b0;
        spi_tx_valid = 1'b0;
      end
      if (spi_rx_valid === 1'b1) ok = 1'b1;
    end
    spi_start    = 1'b0;
    spi_tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    vectors += 6;
    if (sclk !== 1'b1)         begin miscompares++; $display("FAIL reset_sclk: got %b expected 1", sclk); end
    if (mosi !== 1'b0)         begin miscompares++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    if (spi_busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b expected 0", spi_busy); end
    if (spi_tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", spi_tx_ready); end
    if (spi_rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b expected 0", spi_rx_valid); end
    if (spi_rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h expected 00", spi_rx_data); end
  endtask

  task automatic test_basic;
    int base, cyc, v0;
    bit ok;
    logic [7:0] exp_rx;
    exp_rx = expected_rx(8'hA5, 8'h3C);
    v0 = valid_cnt;
    start_byte(8'hA5, 8'h3C, base);
    vectors += 2;
    if (spi_busy !== 1'b1)     begin miscompares++; $display("FAIL basic_busy_at_t0: got %b expected 1", spi_busy); end
    if (spi_tx_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_at_t0: got %b expected 0", spi_tx_ready); end
    wait_done(1'b0, cyc, ok);
    vectors += 7;
    if (!ok)                   begin miscompares++; $display("FAIL basic_timeout: got no rx_valid expected one"); end
    if (cyc != LAT)            begin miscompares++; $display("FAIL basic_latency: got %0d expected %0d", cyc, LAT); end
    if (spi_rx_data !== exp_rx) begin miscompares++; $display("FAIL basic_rx_data: got %h expected %h", spi_rx_data, exp_rx); end
    if (mosi_q.size() - base != 8) begin miscompares++; $display("FAIL basic_rises: got %0d expected 8", mosi_q.size() - base); end
    if (observed_mosi(base) !== 8'hA5) begin miscompares++; $display("FAIL basic_mosi: got %h expected a5", observed_mosi(base)); end
    if (spi_busy !== 1'b0)     begin miscompares++; $display("FAIL basic_busy_done: got %b expected 0", spi_busy); end
    if (spi_tx_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_done: got %b expected 1", spi_tx_ready); end
    @(negedge clk);
    vectors += 2;
    if (spi_rx_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pulse_width: got %b expected 0", spi_rx_valid); end
    if (valid_cnt - v0 != 1)   begin miscompares++; $display("FAIL basic_valid_count: got %0d expected 1", valid_cnt - v0); end
  endtask

  task automatic test_ignore;
    int base, cyc, v0;
    bit ok;
    logic [7:0] tx, sl, exp_rx;
    tx = 8'($urandom_range(0, 254));
    sl = 8'($urandom);
    exp_rx = expected_rx(tx, sl);
    v0 = valid_cnt;
    start_byte(tx, sl, base);
    wait_done(1'b1, cyc, ok);
    vectors += 4;
    if (!ok || cyc != LAT)      begin miscompares++; $display("FAIL ignore_latency: got %0d expected %0d", cyc, LAT); end
    if (spi_rx_data !== exp_rx) begin miscompares++; $display("FAIL ignore_rx_data: got %h expected %h", spi_rx_data, exp_rx); end
    if (observed_mosi(base) !== tx) begin miscompares++; $display("FAIL ignore_mosi: got %h expected %h", observed_mosi(base), tx); end
    if (mosi_q.size() - base != 8) begin miscompares++; $display("FAIL ignore_rises: got %0d expected 8", mosi_q.size() - base); end
    // start without tx_valid in IDLE must be ignored
    @(negedge clk);
    spi_start    = 1'b1;
    spi_tx_valid = 1'b0;
    spi_tx_data  = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (spi_busy !== 1'b0) begin miscompares++; $display("FAIL ignore_no_valid_busy: got %b expected 0", spi_busy); end
    end
    spi_start = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    vectors += 2;
    if (valid_cnt - v0 != 1) begin miscompares++; $display("FAIL ignore_valid_count: got %0d expected 1", valid_cnt - v0); end
    if (mosi_q.size() - base != 8) begin miscompares++; $display("FAIL ignore_extra_rises: got %0d expected 8", mosi_q.size() - base); end
  endtask

  task automatic test_back_to_back;
    int base1, base2, cyc, v0;
    bit ok;
    logic [7:0] s1, s2, e1, e2;
    s1 = 8'($urandom);
    s2 = 8'($urandom);
    e1 = expected_rx(8'h01, s1);
    e2 = expected_rx(8'h80, s2);
    v0 = valid_cnt;
    start_byte(8'h01, s1, base1);
    wait_done(1'b0, cyc, ok);
    vectors += 4;
    if (!ok || cyc != LAT)      begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected %0d", cyc, LAT); end
    if (spi_rx_data !== e1)     begin miscompares++; $display("FAIL b2b_first_rx: got %h expected %h", spi_rx_data, e1); end
    if (observed_mosi(base1) !== 8'h01) begin miscompares++; $display("FAIL b2b_first_mosi: got %h expected 01", observed_mosi(base1)); end
    if (spi_busy !== 1'b0)      begin miscompares++; $display("FAIL b2b_idle_gap: got %b expected 0", spi_busy); end
    start_byte(8'h80, s2, base2);
    vectors++;
    if (spi_busy !== 1'b1)      begin miscompares++; $display("FAIL b2b_reaccept: got %b expected 1", spi_busy); end
    wait_done(1'b0, cyc, ok);
    vectors += 4;
    if (!ok || cyc != LAT)      begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected %0d", cyc, LAT); end
    if (spi_rx_data !== e2)     begin miscompares++; $display("FAIL b2b_second_rx: got %h expected %h", spi_rx_data, e2); end
    if (observed_mosi(base2) !== 8'h80) begin miscompares++; $display("FAIL b2b_second_mosi: got %h expected 80", observed_mosi(base2)); end
    if (valid_cnt - v0 != 2)    begin miscompares++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int base, cyc, v0, f0;
    bit ok, seen;
    logic [7:0] sl, exp_rx;
    f0 = fall_cnt;
    start_byte(8'h55, 8'($urandom), base);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (fall_cnt - f0 >= 4) seen = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL abort_edge7_timeout: got %0d falls expected 4", fall_cnt - f0); end
    v0 = valid_cnt;
    rst_n = 1'b0;
    #1;
    vectors += 6;
    if (sclk !== 1'b1)         begin miscompares++; $display("FAIL abort_sclk: got %b expected 1", sclk); end
    if (mosi !== 1'b0)         begin miscompares++; $display("FAIL abort_mosi: got %b expected 0", mosi); end
    if (spi_busy !== 1'b0)     begin miscompares++; $display("FAIL abort_busy: got %b expected 0", spi_busy); end
    if (spi_tx_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b expected 1", spi_tx_ready); end
    if (spi_rx_valid !== 1'b0) begin miscompares++; $display("FAIL abort_rx_valid: got %b expected 0", spi_rx_valid); end
    if (spi_rx_data !== 8'h00) begin miscompares++; $display("FAIL abort_rx_data: got %h expected 00", spi_rx_data); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sl = 8'($urandom);
    exp_rx = expected_rx(8'h55, sl);
    start_byte(8'h55, sl, base);
    vectors++;
    if (spi_busy !== 1'b1) begin miscompares++; $display("FAIL abort_first_edge_accept: got %b expected 1", spi_busy); end
    wait_done(1'b0, cyc, ok);
    vectors += 4;
    if (!ok || cyc != LAT)      begin miscompares++; $display("FAIL abort_retry_latency: got %0d expected %0d", cyc, LAT); end
    if (spi_rx_data !== exp_rx) begin miscompares++; $display("FAIL abort_retry_rx: got %h expected %h", spi_rx_data, exp_rx); end
    if (observed_mosi(base) !== 8'h55) begin miscompares++; $display("FAIL abort_retry_mosi: got %h expected 55", observed_mosi(base)); end
    if (valid_cnt - v0 != 1)    begin miscompares++; $display("FAIL abort_valid_count: got %0d expected 1", valid_cnt - v0); end
    @(negedge clk);
  endtask

  task automatic test_loopback;
    int base, cyc;
    bit ok;
    logic [7:0] exp_rx;
    exp_rx = expected_rx(8'hC3, 8'h00);
    start_byte(8'hC3, 8'h00, base);
    wait_done(1'b0, cyc, ok);
    vectors += 3;
    if (!ok || cyc != LAT)      begin miscompares++; $display("FAIL loopback_latency: got %0d expected %0d", cyc, LAT); end
    if (spi_rx_data !== exp_rx) begin miscompares++; $display("FAIL loopback_rx: got %h expected %h", spi_rx_data, exp_rx); end
    if (observed_mosi(base) !== 8'hC3) begin miscompares++; $display("FAIL loopback_mosi: got %h expected c3", observed_mosi(base)); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int base, cyc, gap;
    bit ok;
    logic [7:0] tx, sl, exp_rx;
    for (int n = 0; n < 12; n++) begin
      tx = 8'($urandom);
      sl = 8'($urandom);
      exp_rx = expected_rx(tx, sl);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      start_byte(tx, sl, base);
      wait_done(1'b0, cyc, ok);
      vectors += 3;
      if (!ok || cyc != LAT)      begin miscompares++; $display("FAIL random_latency[%0d]: got %0d expected %0d", n, cyc, LAT); end
      if (spi_rx_data !== exp_rx) begin miscompares++; $display("FAIL random_rx[%0d]: got %h expected %h", n, spi_rx_data, exp_rx); end
      if (observed_mosi(base) !== tx) begin miscompares++; $display("FAIL random_mosi[%0d]: got %h expected %h", n, observed_mosi(base), tx); end
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    spi_start    = 1'b0;
    spi_tx_valid = 1'b0;
    spi_tx_data  = 8'h00;
    slave_byte   = 8'h00;
    rst_n        = 1'b1;
    #1 rst_n     = 1'b0;
    test_reset;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_basic;
    test_ignore;
    test_back_to_back;
    test_reset_abort;
    test_loopback;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_byte_master.md
SPI_BYTE_MASTER -- requirements
Module: spi_byte_master

Interface
REQ-001 SHALL provide parameter: CLK_DIV, 2, clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL provide port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: spi_start  input  1  transfer request, sampled each clk.
REQ-005 SHALL provide port: spi_tx_valid  input  1  spi_tx_data valid; must accompany spi_start.
REQ-006 SHALL provide port: spi_tx_data  input  8  byte to transmit, MSB first.
REQ-007 SHALL provide port: spi_tx_ready  output  1  high when a new byte can be accepted.
REQ-008 SHALL provide port: spi_rx_valid  output  1  one-cycle pulse, spi_rx_data updated.
REQ-009 SHALL provide port: spi_rx_data  output  8  last received byte, held until next update.
REQ-010 SHALL provide port: spi_busy  output  1  transfer in progress.
REQ-011 SHALL provide port: sclk  output  1  SPI clock, mode 3 (CPOL=1, CPHA=1).
REQ-012 SHALL provide port: mosi  output  1  serial data out.
REQ-013 SHALL provide port: miso  input  1  serial data in.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on accept, SHIFT->DONE after 16th SCLK edge, DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL accept a byte (edge t0) only when in IDLE with spi_start=1 and spi_tx_valid=1; otherwise spi_start is ignored.
REQ-016 SHALL ignore spi_start/spi_tx_valid while spi_busy=1, with no effect on the ongoing transfer.
REQ-017 SHALL at t0 latch spi_tx_data into tx shift register, drive mosi=spi_tx_data[7], set spi_busy=1, spi_tx_ready=0, clear rx shift register and divider.
REQ-018 SHALL produce SCLK edge k (k=1..16) at edge t0+k*CLK_DIV; odd k falling, even k rising.
REQ-019 SHALL hold mosi=bit 7 through edges 1-2 and advance mosi to the next lower bit on falling edges k=3,5,...,15.
REQ-020 SHALL sample miso on rising edges k=2,4,...,16, shifting into rx register LSB (MSB first).
REQ-021 SHALL at edge t0+16*CLK_DIV+1 load spi_rx_data, pulse spi_rx_valid for exactly one cycle, set spi_busy=0, spi_tx_ready=1.
REQ-022 SHALL accept a new byte on the same cycle spi_rx_valid is high (back-to-back), giving exactly one idle cycle of spi_busy=0.
REQ-023 SHALL hold sclk=1 and mosi=0 whenever not in SHIFT.
REQ-024 SHALL keep spi_tx_ready == !spi_busy at all times.
REQ-025 SHALL size the divider counter to hold CLK_DIV-1 without wrap; divider restarts at 0 after each SCLK edge.

Reset
REQ-026 SHALL, on rst_n=0, immediately force: state IDLE, sclk=1, mosi=0, spi_busy=0, spi_tx_ready=1, spi_rx_valid=0, spi_rx_data=8'h00, shift registers and divider 0.
REQ-027 SHALL abort any in-progress transfer on reset with no spi_rx_valid pulse and no partial spi_rx_data update.
REQ-028 SHALL accept a new transfer on the first clk edge after rst_n deasserts.

Configuration
REQ-029 SHALL support macro SPI_LOOPBACK_EN: when defined, the rx sampler uses internal mosi instead of miso (miso ignored), so spi_rx_data equals the transmitted byte.
REQ-030 SHALL, without SPI_LOOPBACK_EN, sample the external miso port as in REQ-020; all timing identical in both builds.

Verification
REQ-031 SHALL verify reset: rst_n=0 -> sclk=1, mosi=0, spi_busy=0, spi_tx_ready=1, spi_rx_valid=0, spi_rx_data=8'h00.
REQ-032 SHALL verify CLK_DIV=2, tx 8'hA5, slave model drives 8'h3C on falling edges -> 8 rising edges, mosi at rising edges 1,0,1,0,0,1,0,1, spi_rx_data=8'h3C, single spi_rx_valid at t0+33.
REQ-033 SHALL verify spi_start with 8'hFF mid-transfer, and spi_start with spi_tx_valid=0 in IDLE -> both ignored, exactly one spi_rx_valid per accepted byte.
REQ-034 SHALL verify back-to-back 8'h01 then 8'h80 started on the rx_valid cycle -> spi_busy low exactly one cycle, both bytes shifted correctly.
REQ-035 SHALL verify rst_n pulsed after SCLK edge 7 of 8'h55 -> immediate idle values, no spi_rx_valid; subsequent 8'h55 transfer completes normally.
REQ-036 SHALL verify with SPI_LOOPBACK_EN defined, miso tied 0, tx 8'hC3 -> spi_rx_data=8'hC3.
